// File: rtl/cpu_controller.sv
// cpu_controller
//   Eight-phase instruction sequencer for the 8-bit accumulator CPU. It steps
//   through fetch (phases 0-3) and execute (phases 4-7) once per instruction,
//   decodes the current opcode into the datapath strobes, and parks in a
//   sticky HALTED state when it executes HLT.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   opcode  in   opcode held in the instruction register
//   zero    in   ALU is_zero flag (accumulator == 0)
//   sel     out  address mux select: 1 = PC, 0 = IR operand
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   inc_pc  out  PC increment
//   ld_pc   out  PC load from IR operand
//   ld_ac   out  accumulator load from alu_out
//   data_e  out  drive accumulator onto the data bus
//   wr      out  memory write strobe
//   halt    out  processor halted, sticky until reset
//   phase   out  current phase 0..7 (HALTED reports 4)
module cpu_controller #(
  parameter int OPC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             wr,
  output logic             halt,
  output logic [2:0]       phase
);

  localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPC_W-1:0] OP_AND = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPC_W-1:0] OP_STO = 3'd6;
  localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

  // The low three bits of the encoding are the phase number; HALTED sits
  // outside the 0..7 ring so it can never be reached by simple stepping.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  state_e state_q, state_d;
  logic   aluop;

  // Instructions whose result comes back through the ALU into the accumulator.
  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a fixed ring, except HLT branches off in OP_ADDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (opcode == OP_HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      HALTED:     state_d = HALTED;
      default:    state_d = INST_ADDR;
    endcase
  end

  // Output decode. Reset forces INST_ADDR asynchronously, so every strobe
  // except sel drops as soon as rst_n falls. The opcode is decoded as-is in
  // every state; an IR glitch just changes the strobes it produces.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    phase  = state_q[2:0];
    case (state_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        // Unconditional, so HLT leaves the PC pointing past itself.
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        // zero still reflects the accumulator before this instruction.
        rd     = aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      STORE: begin
        rd     = aluop;
        inc_pc = (opcode == OP_JMP);
        ld_pc  = (opcode == OP_JMP);
        ld_ac  = aluop;
        data_e = (opcode == OP_STO);
        wr     = (opcode == OP_STO);
      end
      HALTED: begin
        halt  = 1'b1;
        phase = 3'd4;
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
//   Self-checking bench for cpu_controller. Directed instruction runs from the
//   test plan are followed by randomized instruction streams (with occasional
//   IR glitches and HLTs); every cycle the DUT outputs are compared against a
//   behavioural model that tracks the phase count and halted flag and derives
//   the expected strobes from the instruction-level rules.
module tb_cpu_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;

  int numChecks = 0;
  int numFails  = 0;

  // Reference model state
  int mPhase  = 0;
  bit mHalted = 0;

  cpu_controller #(.OPC_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .data_e (data_e),
    .wr     (wr),
    .halt   (halt),
    .phase  (phase)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobe vector {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt,phase}
  // derived from what each instruction needs in each phase.
  function automatic logic [11:0] modelOut(int ph, bit hlt, logic [2:0] op, logic z);
    bit isAlu;
    bit s, r, li, ip, lp, la, de, w, h;
    logic [2:0] p;
    isAlu = (op >= 3'd2) && (op <= 3'd5);
    if (hlt) begin
      return {9'b0_0000_0001, 3'd4};
    end
    p  = ph[2:0];
    s  = (ph < 4);
    r  = (ph >= 1 && ph <= 3) || (ph >= 5 && isAlu);
    li = (ph == 2) || (ph == 3);
    ip = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    lp = (op == 3'd7) && (ph >= 6);
    la = (ph == 7) && isAlu;
    de = (op == 3'd6) && (ph >= 6);
    w  = (op == 3'd6) && (ph == 7);
    h  = (ph == 4) && (op == 3'd0);
    return {s, r, li, ip, lp, la, de, w, h, p};
  endfunction

  function automatic logic [11:0] dutOut();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase};
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h (model phase %0d halted %0d)",
               tag, observed, expected, mPhase, mHalted);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs, then let the
  // next rising edge advance both DUT and model, and return on the next
  // falling edge.
  task automatic applyStimulus(input logic [2:0] op, input logic z);
    opcode = op;
    zero   = z;
    #1;
    checkOutput("strobes", 32'(dutOut()), 32'(modelOut(mPhase, mHalted, op, z)));
    checkOutput("wrRdExcl", 32'(wr & rd), 32'd0);
    checkOutput("pcExcl", 32'(ld_pc & inc_pc),
                32'(!mHalted && mPhase == 7 && op == 3'd7));
    @(posedge clk);
    if (!mHalted) begin
      if (mPhase == 4 && op == 3'd0) mHalted = 1;
      else mPhase = (mPhase + 1) % 8;
    end
    @(negedge clk);
  endtask

  // Called at a falling edge: pulse reset for one cycle.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    mPhase  = 0;
    mHalted = 0;
    checkOutput("resetState", 32'(dutOut()), 32'(modelOut(0, 0, opcode, zero)));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full instruction from phase 0 with fixed inputs; stops early on halt.
  task automatic runInstr(input logic [2:0] op, input logic z);
    for (int c = 0; c < 8 && !mHalted; c++) applyStimulus(op, z);
  endtask

  task automatic runHalted(input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(3'($urandom_range(0, 7)), 1'($urandom));
  endtask

  initial begin
    logic [2:0] op;
    rst_n  = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    @(negedge clk);
    checkOutput("resetState", 32'(dutOut()), 32'(modelOut(0, 0, opcode, zero)));
    checkOutput("resetPhase", 32'(phase), 32'd0);
    rst_n = 1'b1;

    // Directed runs from the test plan
    runInstr(3'd2, 1'b0);
    runInstr(3'd6, 1'b0);
    runInstr(3'd1, 1'b1);
    runInstr(3'd1, 1'b0);
    runInstr(3'd7, 1'b0);
    runInstr(3'd0, 1'b0);
    checkOutput("haltEntered", 32'(mHalted), 32'd1);
    runHalted(22);
    checkOutput("haltSticky", 32'({halt, phase}), 32'({1'b1, 3'd4}));
    doReset();
    checkOutput("postHaltPhase", 32'({halt, phase}), 32'({1'b0, 3'd0}));

    // Asynchronous reset in the middle of the STORE phase of an STO
    for (int c = 0; c < 7; c++) applyStimulus(3'd6, 1'b0);
    opcode = 3'd6;
    #1;
    checkOutput("stoStoreWr", 32'({wr, data_e}), 32'({1'b1, 1'b1}));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstStrobes", 32'({wr, data_e}), 32'd0);
    checkOutput("asyncRstState", 32'(dutOut()), 32'(modelOut(0, 0, 3'd6, 1'b0)));
    mPhase  = 0;
    mHalted = 0;
    @(negedge clk);
    checkOutput("rstHeld", 32'({sel, phase}), 32'({1'b1, 3'd0}));
    rst_n = 1'b1;

    // Randomized instruction stream with occasional IR glitches
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd2;
      for (int c = 0; c < 8 && !mHalted; c++) begin
        if ($urandom_range(0, 15) == 0) op = 3'($urandom_range(1, 7));
        applyStimulus(op, 1'($urandom));
      end
      if (mHalted) begin
        runHalted($urandom_range(3, 25));
        doReset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
